// File: rtl/noc_pkg.sv
// Shared NoC definitions: default port geometry, flit control-bit positions and the
// output-arbiter FSM state type.
package noc_pkg;

  localparam int unsigned NumInDef = 5;
  localparam int unsigned FlitWDef = 34;
  localparam int unsigned TailBit  = FlitWDef - 1;
  localparam int unsigned HeadBit  = FlitWDef - 2;
  localparam int unsigned PktCntW  = 16;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

  // TAIL position for a non-default flit width; HEAD sits just below it.
  function automatic int unsigned tail_bit(int unsigned flit_w);
    return flit_w - 1;
  endfunction

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Handshake bundle between the router inputs, the output arbiter and the downstream link.
// The master modport is the arbiter's view; slave is the surrounding router/link.
interface noc_output_arbiter_if #(
  parameter int unsigned NUM_IN = noc_pkg::NumInDef,
  parameter int unsigned FLIT_W = noc_pkg::FlitWDef
);

  logic [NUM_IN-1:0]          in_valid;
  logic [NUM_IN*FLIT_W-1:0]   in_flit;
  logic [NUM_IN-1:0]          in_ready;
  logic                       out_valid;
  logic [FLIT_W-1:0]          out_flit;
  logic                       out_ready;
  logic [NUM_IN-1:0]          grant;
  logic                       busy;
  logic [noc_pkg::PktCntW-1:0] pkt_count;

  modport master (
    input  in_valid, in_flit, out_ready,
    output in_ready, out_valid, out_flit, grant, busy, pkt_count
  );

  modport slave (
    output in_valid, in_flit, out_ready,
    input  in_ready, out_valid, out_flit, grant, busy, pkt_count
  );

endinterface

// File: rtl/rr_picker.sv
// Rotating-priority picker: selects the first asserted request at or above ptr,
// wrapping modulo N. Purely combinational.
module rr_picker #(
  parameter int unsigned N    = 5,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [IdxW-1:0] idx
);

  logic        found;
  int unsigned pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr) + k) % N;
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IdxW'(pos);
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole output-port arbiter: round-robin grant on the first flit, then the owner
// holds the port until a TAIL flit is transferred.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NUM_IN = NumInDef,
  parameter int unsigned FLIT_W = FlitWDef
) (
  input  logic                clk,
  input  logic                preset,
  noc_output_arbiter_if.master bus
);

  localparam int unsigned     IdxW    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned     Tail    = tail_bit(FLIT_W);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_IN - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_IN-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PktCntW-1:0]   pkt_count_q, pkt_count_d;

  logic [NUM_IN-1:0]    pick_onehot;
  logic [IdxW-1:0]      pick_idx;
  logic [FLIT_W-1:0]    owner_flit;
  logic [NUM_IN-1:0]    in_ready;
  logic [FLIT_W-1:0]    out_flit;
  logic                 out_valid;
  logic                 xfer;

  rr_picker #(
    .N    (NUM_IN),
    .IdxW (IdxW)
  ) u_picker (
    .req    (bus.in_valid),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign owner_flit = bus.in_flit[owner_q * FLIT_W +: FLIT_W];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_count_d = pkt_count_q;
    in_ready    = '0;
    out_valid   = 1'b0;
    out_flit    = '0;
    xfer        = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Any valid flit requests the port; HEAD is deliberately not inspected.
        if (|bus.in_valid) begin
          state_d = StLocked;
          grant_d = pick_onehot;
          owner_d = pick_idx;
        end
      end
      StLocked: begin
        out_valid          = bus.in_valid[owner_q];
        out_flit           = owner_flit;
        in_ready[owner_q]  = bus.out_ready;
        xfer               = out_valid & bus.out_ready;
        // Lock is held across owner bubbles; only a transferred TAIL releases it.
        if (xfer && owner_flit[Tail]) begin
          state_d     = StIdle;
          grant_d     = '0;
          rr_ptr_d    = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
          pkt_count_d = pkt_count_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (preset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_flit  = out_flit;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == StLocked);
  assign bus.pkt_count = pkt_count_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: per-input flit drivers, an expected-transfer scoreboard
// popped by an output monitor, plus directed cycle-level checks of grant/busy/count.
module tb_noc_output_arbiter;
  import noc_pkg::*;

  localparam int unsigned NUM_IN = NumInDef;
  localparam int unsigned FLIT_W = FlitWDef;
  localparam int unsigned Depth  = 32;

  typedef struct packed {
    logic [FLIT_W-1:0] flit;
    logic [NUM_IN-1:0] grant;
  } exp_t;

  logic clk;
  logic preset;

  noc_output_arbiter_if #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W)) bus ();

  noc_output_arbiter #(
    .NUM_IN (NUM_IN),
    .FLIT_W (FLIT_W)
  ) dut (
    .clk    (clk),
    .preset (preset),
    .bus    (bus)
  );

  logic [FLIT_W-1:0] src_mem [NUM_IN][Depth];
  int                wr [NUM_IN];
  int                rd [NUM_IN];
  logic [NUM_IN-1:0] hold;
  logic [NUM_IN-1:0] acc;
  exp_t              exp_q [$];
  int                n_vec;
  int                n_bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic logic [FLIT_W-1:0] mk(logic head, logic tail, logic [31:0] pay);
    logic [FLIT_W-1:0] f;
    f            = '0;
    f[31:0]      = pay;
    f[HeadBit]   = head;
    f[TailBit]   = tail;
    return f;
  endfunction

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < NUM_IN; i++) p += wr[i] - rd[i];
    return p;
  endfunction

  task automatic send(int port, logic [FLIT_W-1:0] f);
    src_mem[port][wr[port]] = f;
    wr[port]++;
  endtask

  task automatic expect_xfer(int port, logic [FLIT_W-1:0] f);
    exp_t e;
    e.flit        = f;
    e.grant       = '0;
    e.grant[port] = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic pkt(int port, int n, logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      logic [FLIT_W-1:0] f;
      f = mk(k == 0, k == n - 1, base + 32'(k));
      send(port, f);
      expect_xfer(port, f);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    preset    = 1'b1;
    out_ready_drive(1'b0);
    step();
    step();
    preset = 1'b0;
  endtask

  task automatic out_ready_drive(logic v);
    bus.out_ready = v;
  endtask

  task automatic wait_idle(string name);
    bit done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (bus.busy === 1'b0) && (pending() == 0);
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_drain: busy %0b with %0d flits owed, expected idle and drained",
               name, bus.busy, exp_q.size());
    end
  endtask

  // Upstream drivers: present the head of each input queue; pop on a sampled handshake.
  initial begin
    bus.in_valid = '0;
    bus.in_flit  = '0;
    for (int i = 0; i < NUM_IN; i++) rd[i] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NUM_IN; i++) begin
        if (acc[i]) rd[i]++;
        if (rd[i] < wr[i] && !hold[i]) begin
          bus.in_valid[i]                  = 1'b1;
          bus.in_flit[i*FLIT_W +: FLIT_W]  = src_mem[i][rd[i]];
        end else begin
          bus.in_valid[i]                  = 1'b0;
          bus.in_flit[i*FLIT_W +: FLIT_W]  = '0;
        end
      end
    end
  end

  initial begin
    acc = '0;
    forever begin
      @(negedge clk);
      acc = bus.in_valid & bus.in_ready & {NUM_IN{~preset}};
    end
  end

  // Output monitor: every downstream transfer must match the next expected flit.
  initial begin
    forever begin
      @(negedge clk);
      if (preset !== 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_xfer: got flit %0h, expected no transfer", bus.out_flit);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("xfer_flit", bus.out_flit, e.flit);
          check("xfer_grant", bus.grant, e.grant);
        end
      end
    end
  end

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    hold   = '0;
    preset = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NUM_IN; i++) wr[i] = 0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_pkt_count", bus.pkt_count, 0);

    // Single requester, 3-flit packet
    step();
    bus.out_ready = 1'b1;
    pkt(0, 3, 32'h1000);
    @(negedge clk);
    check("single_c0_grant", bus.grant, 0);
    check("single_c0_in_ready", bus.in_ready, 0);
    check("single_c0_out_valid", bus.out_valid, 0);
    check("single_c0_out_flit", bus.out_flit, 0);
    @(negedge clk);
    check("single_c1_grant", bus.grant, 5'b00001);
    check("single_c1_busy", bus.busy, 1);
    check("single_c1_out_valid", bus.out_valid, 1);
    repeat (3) @(negedge clk);
    check("single_c4_busy", bus.busy, 0);
    check("single_c4_pkt_count", bus.pkt_count, 1);
    check("single_c4_grant", bus.grant, 0);
    wait_idle("single");

    // Round-robin between inputs 0 and 2 from a fresh pointer
    do_reset();
    @(negedge clk);
    check("rr_rst_pkt_count", bus.pkt_count, 0);
    step();
    bus.out_ready = 1'b1;
    pkt(0, 1, 32'h2000);
    pkt(2, 1, 32'h2100);
    pkt(0, 1, 32'h2001);
    pkt(2, 1, 32'h2101);
    begin
      logic [NUM_IN-1:0] rr_tbl [8];
      rr_tbl = '{5'b00000, 5'b00001, 5'b00000, 5'b00100,
                 5'b00000, 5'b00001, 5'b00000, 5'b00100};
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        check("rr_grant", bus.grant, rr_tbl[c]);
      end
    end
    wait_idle("rr");
    check("rr_pkt_count", bus.pkt_count, 4);

    // Wrap-around: input 3 alone moves the pointer to 4, then inputs 4 and 1 compete
    step();
    pkt(3, 1, 32'h3000);
    wait_idle("wrap_pre");
    step();
    pkt(4, 1, 32'h3100);
    pkt(1, 1, 32'h3200);
    @(negedge clk);
    check("wrap_c0_grant", bus.grant, 0);
    @(negedge clk);
    check("wrap_c1_grant", bus.grant, 5'b10000);
    @(negedge clk);
    check("wrap_c2_grant", bus.grant, 0);
    @(negedge clk);
    check("wrap_c3_grant", bus.grant, 5'b00010);
    wait_idle("wrap");
    // Pointer now 2: of inputs 0 and 2, input 2 must win first
    step();
    pkt(2, 1, 32'h3300);
    pkt(0, 1, 32'h3400);
    @(negedge clk);
    @(negedge clk);
    check("wrap_ptr2_grant", bus.grant, 5'b00100);
    @(negedge clk);
    @(negedge clk);
    check("wrap_next_grant", bus.grant, 5'b00001);
    wait_idle("wrap_ptr");

    // Backpressure then owner bubble, with input 0 waiting behind the lock
    step();
    pkt(3, 4, 32'h4000);
    @(negedge clk);
    check("bp_c0_grant", bus.grant, 0);
    @(negedge clk);
    check("bp_c1_grant", bus.grant, 5'b01000);
    check("bp_c1_flit", bus.out_flit, mk(1'b1, 1'b0, 32'h4000));
    step();
    bus.out_ready = 1'b0;
    pkt(0, 1, 32'h4100);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_stall_valid", bus.out_valid, 1);
      check("bp_stall_flit", bus.out_flit, mk(1'b0, 1'b0, 32'h4001));
      check("bp_stall_in_ready", bus.in_ready, 0);
      check("bp_stall_grant", bus.grant, 5'b01000);
      step();
    end
    bus.out_ready = 1'b1;
    hold = 5'b01000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("bubble_out_valid", bus.out_valid, 0);
      check("bubble_busy", bus.busy, 1);
      check("bubble_in_ready", bus.in_ready, 5'b01000);
      check("bubble_grant", bus.grant, 5'b01000);
      step();
    end
    hold = '0;
    wait_idle("bp");
    check("bp_pkt_count", bus.pkt_count, 11);

    // Reset after flit 2 of 4; flits 3-4 re-arbitrate, pointer restarts at 0
    step();
    send(2, mk(1'b1, 1'b0, 32'h5000));
    send(2, mk(1'b0, 1'b0, 32'h5001));
    send(2, mk(1'b0, 1'b0, 32'h5002));
    send(2, mk(1'b0, 1'b1, 32'h5003));
    expect_xfer(2, mk(1'b1, 1'b0, 32'h5000));
    expect_xfer(2, mk(1'b0, 1'b0, 32'h5001));
    @(negedge clk);
    @(negedge clk);
    check("mid_c1_grant", bus.grant, 5'b00100);
    @(negedge clk);
    step();
    bus.out_ready = 1'b0;
    preset = 1'b1;
    step();
    preset = 1'b0;
    bus.out_ready = 1'b1;
    send(0, mk(1'b1, 1'b1, 32'h5100));
    expect_xfer(0, mk(1'b1, 1'b1, 32'h5100));
    expect_xfer(2, mk(1'b0, 1'b0, 32'h5002));
    expect_xfer(2, mk(1'b0, 1'b1, 32'h5003));
    @(negedge clk);
    check("mid_rst_grant", bus.grant, 0);
    check("mid_rst_pkt_count", bus.pkt_count, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    check("mid_ptr0_grant", bus.grant, 5'b00001);
    wait_idle("mid");
    check("mid_pkt_count", bus.pkt_count, 2);

    // Counter wrap: jump near the top of the range, then real one-flit packets
    step();
    force dut.pkt_count_q = 16'hfff0;
    step();
    release dut.pkt_count_q;
    for (int k = 0; k < 15; k++) pkt(4, 1, 32'h6000 + 32'(k));
    wait_idle("cnt_top");
    check("cnt_ffff", bus.pkt_count, 16'hffff);
    step();
    pkt(4, 1, 32'h6100);
    wait_idle("cnt_wrap");
    check("cnt_wrap_zero", bus.pkt_count, 0);

    check("scoreboard_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
